vc_output_arbiter: RTL

//  Per-output-port allocator and switch for the virtual-channel router.

---
 rtl/vc_output_arbiter.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/vc_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vc_output_arbiter
// Purpose  : Per-output-port allocator and switch for the virtual-channel
//            router. Round-robin arbitration among input VCs whose header is
//            routed to this output. The grant is held for the whole packet,
//            and the winner's flits are muxed onto the output link. The grant
//            is released on the tail flit.
// Config   : VC_ARB_TIMEOUT_EN - when defined, a TIMEOUT_W-bit watchdog
//            force-releases a grant whose VC stops delivering flits.
// Ports    : clk_i, rst_ni (async active-low)
//            req_i        - per-VC request (header routed here)
//            flit_i       - packed VC flits, VC i at [i*FLIT_W +: FLIT_W]
//            flit_vld_i   - per-VC flit valid
//            out_rdy_i    - downstream buffer not full
//            chan_alloc_o - one-hot grant, held for the whole packet
//            chan_rdy_o   - grant qualified by out_rdy_i
//            out_flit_o   - granted VC's flit (0 when no grant)
//            out_vld_o    - granted VC's flit valid
//            grant_idx_o  - index of granted VC (valid while busy_o)
//            busy_o       - grant held
//            timeout_o    - one-cycle watchdog release pulse
// Revision : 1.0 - initial release
// ============================================================================

`ifndef HEADER_ID
`define HEADER_ID 2'b01
`endif
`ifndef TAIL_ID
`define TAIL_ID 2'b11
`endif

module vc_output_arbiter #(
    parameter int IN_N        = 5,
    parameter int IDX_W       = 3,
    parameter int FLIT_DATA_W = 8,
    parameter int FLIT_ID_W   = 2,
    parameter int TIMEOUT_W   = 8
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic [IN_N-1:0]                               req_i,
    input  logic [IN_N*(FLIT_DATA_W+FLIT_ID_W)-1:0]       flit_i,
    input  logic [IN_N-1:0]                               flit_vld_i,
    input  logic                                          out_rdy_i,
    output logic [IN_N-1:0]                               chan_alloc_o,
    output logic [IN_N-1:0]                               chan_rdy_o,
    output logic [FLIT_DATA_W+FLIT_ID_W-1:0]              out_flit_o,
    output logic                                          out_vld_o,
    output logic [IDX_W-1:0]                              grant_idx_o,
    output logic                                          busy_o,
    output logic                                          timeout_o
);

    localparam int FLIT_W = FLIT_DATA_W + FLIT_ID_W;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [IN_N-1:0]   alloc_q, alloc_d;
    logic [IDX_W-1:0]  gidx_q,  gidx_d;
    logic [IDX_W-1:0]  ptr_q,   ptr_d;

    // Unpack the flat flit bus so the switch is a plain array select.
    logic [FLIT_W-1:0] flit_arr [IN_N];

    generate
        for (genvar gi = 0; gi < IN_N; gi++) begin : g_unpack
            assign flit_arr[gi] = flit_i[gi*FLIT_W +: FLIT_W];
        end
    endgenerate

    logic              busy;
    logic [FLIT_W-1:0] flit_g;
    logic              vld_g;
    logic              is_tail;
    logic              expire;
    logic [IDX_W-1:0]  ptr_after_g;

    assign busy    = (state_q == ST_BUSY);
    assign flit_g  = flit_arr[gidx_q];
    assign vld_g   = flit_vld_i[gidx_q];
    assign is_tail = busy && vld_g &&
                     (flit_g[FLIT_W-1 -: FLIT_ID_W] == FLIT_ID_W'(`TAIL_ID));

    // After a release the search starts one past the VC just served.
    assign ptr_after_g = (gidx_q == IDX_W'(IN_N - 1)) ? '0 : gidx_q + 1'b1;

    // ------------------------------------------------------------------
    // Round-robin winner: first requester at ptr, ptr+1, ... wrapping.
    // The candidate is kept one bit wider than the index so the wrap
    // subtraction cannot overflow.
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] win_idx;
    logic             win_found;
    logic [IDX_W:0]   cand;

    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int k = 0; k < IN_N; k++) begin
            cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(IN_N)) begin
                cand = cand - (IDX_W+1)'(IN_N);
            end
            if (!win_found && req_i[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
`ifdef VC_ARB_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

    // A flit in the same cycle the counter is full rescues the grant.
    assign expire = busy && (&cnt_q) && !vld_g;

    always_comb begin
        cnt_d = cnt_q;
        if (!busy || vld_g) begin
            cnt_d = '0;
        end else if (!(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_o = expire;
`else
    assign expire    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Allocation FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        alloc_d = alloc_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    alloc_d = {{(IN_N-1){1'b0}}, 1'b1} << win_idx;
                    gidx_d  = win_idx;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Release goes through IDLE, so new requests always see
                // one bubble cycle before the next grant.
                if (is_tail || expire) begin
                    alloc_d = '0;
                    ptr_d   = ptr_after_g;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                alloc_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            alloc_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            alloc_q <= alloc_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
        end
    end

    // ------------------------------------------------------------------
    // Switch: zero-latency path from the registered grant
    // ------------------------------------------------------------------
    assign chan_alloc_o = alloc_q;
    assign chan_rdy_o   = alloc_q & {IN_N{out_rdy_i}};
    assign out_flit_o   = busy ? flit_g : '0;
    assign out_vld_o    = busy & vld_g;
    assign grant_idx_o  = gidx_q;
    assign busy_o       = busy;

endmodule

`default_nettype wire
